// File: rtl/uart_tx_serial_if.sv
// rtl/uart_tx_serial_if.sv - byte handshake and serial line bundle for the UART transmit serializer
//
// Purpose:
//   Groups the control-unit-facing handshake (TRANS/DATATX in, BUSY/TX_DONE out)
//   and the serial TX line of uart_tx_serial.
//
// Signals:
//   TRANS    1  start strobe from the control unit
//   DATATX   8  byte to transmit
//   TX       1  serial line, idles high
//   BUSY     1  frame in progress
//   TX_DONE  1  one-cycle frame completion pulse
//
// Modports:
//   master  control-unit side (drives TRANS/DATATX)
//   slave   serializer side (drives TX/BUSY/TX_DONE)

interface uart_tx_serial_if;
  logic       TRANS;
  logic [7:0] DATATX;
  logic       TX;
  logic       BUSY;
  logic       TX_DONE;

  modport master (
    output TRANS,
    output DATATX,
    input  TX,
    input  BUSY,
    input  TX_DONE
  );

  modport slave (
    input  TRANS,
    input  DATATX,
    output TX,
    output BUSY,
    output TX_DONE
  );
endinterface

// File: rtl/uart_tx_serial.sv
// rtl/uart_tx_serial.sv - UART transmit serializer, 8N1/8N2 framing, LSB first
//
// Purpose:
//   Accepts a byte on a one-cycle TRANS strobe while idle and shifts it out on
//   TX as start bit, 8 data bits (LSB first), optional even parity bit and
//   STOP_BITS stop bits, each held for BAUD_DIV clock cycles. A one-cycle
//   TX_DONE pulse marks the end of every frame.
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit(s).
//
// Parameters:
//   BAUD_DIV   clock cycles per serial bit (>= 2)
//   STOP_BITS  number of stop bits (1 or 2)
//
// Ports:
//   clk    input   system clock, rising edge
//   reset  input   asynchronous active-low reset
//   bus    slave   TRANS/DATATX in, TX/BUSY/TX_DONE out (all outputs registered)

module uart_tx_serial #(
  parameter int BAUD_DIV  = 5208,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_serial_if.slave  bus
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_idx_next;
  logic [7:0]    w_shift_next;
  logic          w_tx_next;
  logic          w_busy_next;
  logic          w_done_next;
  logic          w_tick;

`ifdef UART_TX_PARITY_EN
  logic          r_parity;
  logic          w_parity_next;
`endif

  // One tick per BAUD_DIV cycles; the counter wraps on the same edge.
  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      IDLE: begin
        if (bus.TRANS) begin
          w_state_next  = START;
          w_cnt_next    = '0;
          w_idx_next    = '0;
          w_shift_next  = bus.DATATX;
          w_busy_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^bus.DATATX;
`endif
        end
      end

      START: begin
        w_cnt_next = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) begin
          w_state_next = DATA;
          w_idx_next   = '0;
        end
      end

      DATA: begin
        w_cnt_next = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_idx_next   = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_cnt_next = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) begin
          w_state_next = STOP;
          w_idx_next   = '0;
        end
      end
`endif

      STOP: begin
        // r_idx counts stop-bit periods here.
        w_cnt_next = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) begin
          if (r_idx == STOP_LAST) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_idx_next   = '0;
        w_busy_next  = 1'b0;
      end
    endcase

    // TX is derived from the state being entered so the registered line
    // changes on the same edge as the state, with no lag of one cycle.
    case (w_state_next)
      START:     w_tx_next = 1'b0;
      DATA:      w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:    w_tx_next = w_parity_next;
`endif
      default:   w_tx_next = 1'b1;
    endcase
  end

  assign bus.TX      = r_tx;
  assign bus.BUSY    = r_busy;
  assign bus.TX_DONE = r_done;

endmodule
